// File: rtl/dcnt_pkg.sv
// Shared definitions for the round-robin down-counter scheduler.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package dcnt_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Ceiling log2, used to size requester indices.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping to 0.
// Latency: zero cycles (pure combinational); the caller registers the result.
// Backpressure: none; the result follows i_req/i_ptr every cycle.
// Ports: i_req (request vector), i_ptr (search start index),
//        o_vld (any request), o_idx (winner index), o_onehot (winner one-hot).
module rr_arbiter
    import dcnt_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_vld,
    output logic [IW-1:0]    o_idx,
    output logic [N_REQ-1:0] o_onehot
);

    // Rotate so the pointer position lands at bit 0; the first set bit of
    // w_rot is then the winner, offset k from the pointer.
    logic [N_REQ-1:0] w_rot;
    logic [IW:0]      w_sum;

    assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_vld    = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_sum    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_vld && w_rot[k]) begin
                o_vld = 1'b1;
                w_sum = {1'b0, i_ptr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N_REQ))
                    w_sum = w_sum - (IW+1)'(N_REQ);
                o_idx = w_sum[IW-1:0];
            end
        end
        o_onehot[o_idx] = o_vld;
    end

endmodule

// File: rtl/down_counter_sched.sv
// Round-robin scheduler sharing one W-bit down counter among N_REQ requesters.
// Latency: grant one edge after req seen in IDLE; start value V gives V COUNT cycles, then a 1-cycle done.
// Backpressure: en low freezes the count; dropping req[cur] during COUNT cancels the job without done.
// Ports: clk, rst (async active-high), req (per-requester level), req_val (start values,
//        slice i = req_val[i*W +: W]), en (count enable), gnt (one-hot grant),
//        done (completion pulse), cnt (counter value), busy (COUNT or DONE).
module down_counter_sched
    import dcnt_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_val,
    input  logic               en,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       cnt,
    output logic               busy
);

    localparam int IW = clog2(N_REQ);

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_gnt,   w_gnt_nxt;
    logic [N_REQ-1:0] r_done,  w_done_nxt;
    logic [W-1:0]     r_cnt,   w_cnt_nxt;
    logic [IW-1:0]    r_cur,   w_cur_nxt;
    logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;

    logic             w_arb_vld;
    logic [IW-1:0]    w_arb_idx;
    logic [N_REQ-1:0] w_arb_onehot;
    logic [W-1:0]     w_val;
    logic [IW-1:0]    w_cur_inc;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .i_req    (req),
        .i_ptr    (r_rr_ptr),
        .o_vld    (w_arb_vld),
        .o_idx    (w_arb_idx),
        .o_onehot (w_arb_onehot)
    );

    assign w_val     = req_val[int'(w_arb_idx)*W +: W];
    // Priority moves to the requester after the one just served, wrapping.
    assign w_cur_inc = (r_cur == IW'(N_REQ-1)) ? '0 : r_cur + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_done   <= '0;
            r_cnt    <= '0;
            r_cur    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cur    <= w_cur_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_cnt_nxt    = r_cnt;
        w_cur_nxt    = r_cur;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                w_cnt_nxt = '0;
                if (w_arb_vld) begin
                    w_gnt_nxt = w_arb_onehot;
                    w_cur_nxt = w_arb_idx;
                    w_cnt_nxt = w_val;
                    // A zero start value skips COUNT and completes immediately.
                    if (w_val == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = w_arb_onehot;
                    end else begin
                        w_state_nxt = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                // Cancel takes priority over enable and completion.
                if (!req[r_cur]) begin
                    w_state_nxt  = S_IDLE;
                    w_gnt_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_rr_ptr_nxt = w_cur_inc;
                end else if (en && r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == W'(1)) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = r_gnt;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt  = S_IDLE;
                w_gnt_nxt    = '0;
                w_cnt_nxt    = '0;
                w_rr_ptr_nxt = w_cur_inc;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign cnt  = r_cnt;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_down_counter_sched.sv
module tb_down_counter_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_val;
    logic        en;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  cnt;
    logic        busy;

    int n_checks;
    int n_pass;

    down_counter_sched #(.N_REQ(4), .W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_val (req_val),
        .en      (en),
        .gnt     (gnt),
        .done    (done),
        .cnt     (cnt),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] val;
        logic        en;
        logic [3:0]  e_gnt;
        logic [3:0]  e_done;
        logic [3:0]  e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] r, input logic [15:0] v, input logic e,
                       input logic [3:0] g, input logic [3:0] d, input logic [3:0] c,
                       input logic b);
        vec_t x;
        x.req = r; x.val = v; x.en = e;
        x.e_gnt = g; x.e_done = d; x.e_cnt = c; x.e_busy = b;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [3:0] g, input logic [3:0] d,
                       input logic [3:0] c, input logic b);
        n_checks++;
        if (gnt === g && done === d && cnt === c && busy === b) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got gnt=%b done=%b cnt=%0d busy=%b, expected gnt=%b done=%b cnt=%0d busy=%b",
                     name, gnt, done, cnt, busy, g, d, c, b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        req      = '0;
        req_val  = '0;
        en       = 1'b1;

        #3;
        chk("reset_state", 4'b0000, 4'b0000, 4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // All four requesting with start value 2: strict rotation 0,1,2,3,0.
        for (int j = 0; j < 5; j++) begin
            oh = 4'b0001 << (j % 4);
            add(4'b1111, 16'h2222, 1'b1, oh, 4'b0000, 4'd2, 1'b1);
            add(4'b1111, 16'h2222, 1'b1, oh, 4'b0000, 4'd1, 1'b1);
            add(4'b1111, 16'h2222, 1'b1, oh, oh,      4'd0, 1'b1);
            add((j == 4) ? 4'b0000 : 4'b1111, 16'h2222, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0);
        end
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0);
        // Single job, start value 5: five COUNT cycles then one done.
        for (int c = 5; c >= 1; c--)
            add(4'b0001, 16'h0005, 1'b1, 4'b0001, 4'b0000, 4'(c), 1'b1);
        add(4'b0001, 16'h0005, 1'b1, 4'b0001, 4'b0001, 4'd0, 1'b1);
        add(4'b0000, 16'h0005, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0);
        // Zero start value goes straight to DONE.
        add(4'b0100, 16'h0000, 1'b1, 4'b0100, 4'b0100, 4'd0, 1'b1);
        add(4'b0000, 16'h0000, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            req     = vecs[i].req;
            req_val = vecs[i].val;
            en      = vecs[i].en;
            step();
            chk($sformatf("vec[%0d]", i), vecs[i].e_gnt, vecs[i].e_done,
                vecs[i].e_cnt, vecs[i].e_busy);
        end
        // rr_ptr is now 3.

        // Cancel: requester 1 with value 9, dropped at cnt=6.
        req     = 4'b0010;
        req_val = 16'h0394;
        en      = 1'b1;
        step(); chk("cancel_grant", 4'b0010, 4'b0000, 4'd9, 1'b1);
        step(); chk("cancel_c8",    4'b0010, 4'b0000, 4'd8, 1'b1);
        step(); chk("cancel_c7",    4'b0010, 4'b0000, 4'd7, 1'b1);
        step(); chk("cancel_c6",    4'b0010, 4'b0000, 4'd6, 1'b1);
        req = 4'b0000;
        step(); chk("cancel_abort", 4'b0000, 4'b0000, 4'd0, 1'b0);
        // Pointer must now be 2: with 0,1,2 requesting, 2 wins.
        req = 4'b0111;
        step(); chk("cancel_ptr2",  4'b0100, 4'b0000, 4'd3, 1'b1);

        // Async reset mid-COUNT at cnt=3: outputs clear without a clock edge.
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset", 4'b0000, 4'b0000, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        // Pointer back to 0, so requester 0 wins over 1 and 2.
        step(); chk("reset_regrant", 4'b0001, 4'b0000, 4'd4, 1'b1);

        // Enable hold at cnt=3 for three cycles.
        step(); chk("hold_c3",  4'b0001, 4'b0000, 4'd3, 1'b1);
        en = 1'b0;
        step(); chk("hold_h1",  4'b0001, 4'b0000, 4'd3, 1'b1);
        step(); chk("hold_h2",  4'b0001, 4'b0000, 4'd3, 1'b1);
        step(); chk("hold_h3",  4'b0001, 4'b0000, 4'd3, 1'b1);
        en = 1'b1;
        step(); chk("hold_c2",  4'b0001, 4'b0000, 4'd2, 1'b1);
        step(); chk("hold_c1",  4'b0001, 4'b0000, 4'd1, 1'b1);
        step(); chk("hold_done",4'b0001, 4'b0001, 4'd0, 1'b1);
        req = 4'b0000;
        step(); chk("hold_idle",4'b0000, 4'b0000, 4'd0, 1'b0);
        step(); chk("hold_stay",4'b0000, 4'b0000, 4'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
